// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the triple-product multiplier:
// field widths, special encodings, FSM state type and field helpers.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL1,
        MUL2,
        DONE
    } state_t;

    function automatic logic get_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [EXP_W-1:0] get_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [MAN_W-1:0] get_man(input logic [31:0] f);
        return f[22:0];
    endfunction

    function automatic logic [31:0] pack_fp(input logic s,
                                            input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/fp_mul_core.sv
// Combinational binary32 x binary32 multiplier: special-value decode,
// one-step normalization, optional rounding, overflow/flush-to-zero.
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even,
// otherwise the product is truncated toward zero.
import fp_pkg::*;

module fp_mul_core (
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] result
);

    logic              sign;
    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [MAN_W-1:0]  fa;
    logic [MAN_W-1:0]  fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       prod;
    logic              norm_shift;
    logic [23:0]       norm;
    logic              round_inc;
    logic [24:0]       rounded;
    logic [MAN_W-1:0]  frac_fin;
    logic signed [10:0] exp_norm;
    logic signed [10:0] exp_fin;
`ifdef FP_ROUND_NEAREST_EN
    logic              guard_bit, round_bit, sticky_bit;
`endif

    // Decode operands, multiply significands, normalize, round and classify.
    // NOTE: every variable assigned here gets a value on every path (defaults
    // first, or a plain assignment), so no latch can be inferred.
    always_comb begin
        sign   = get_sign(op_a) ^ get_sign(op_b);
        ea     = get_exp(op_a);
        eb     = get_exp(op_b);
        fa     = get_man(op_a);
        fb     = get_man(op_b);

        // Denormals have exponent 0 and are treated as signed zero.
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);

        prod       = 48'({1'b1, fa}) * 48'({1'b1, fb});
        // Product of two [1,2) significands lies in [1,4): at most one right shift.
        norm_shift = prod[47];
        norm       = 24'(norm_shift ? (prod >> 24) : (prod >> 23));
        exp_norm   = $signed({3'b000, ea}) + $signed({3'b000, eb})
                   - 11'(EXP_BIAS) + (norm_shift ? 11'sd1 : 11'sd0);

`ifdef FP_ROUND_NEAREST_EN
        guard_bit  = norm_shift ? prod[23] : prod[22];
        round_bit  = norm_shift ? prod[22] : prod[21];
        sticky_bit = norm_shift ? (|prod[21:0]) : (|prod[20:0]);
        // Round up above the halfway point, or at exactly half when the LSB is odd.
        round_inc  = guard_bit & (round_bit | sticky_bit | norm[0]);
`else
        round_inc  = 1'b0;
`endif

        rounded  = {1'b0, norm} + 25'(round_inc);
        // A carry out of the significand means it became exactly 2.0.
        frac_fin = rounded[24] ? rounded[23:1] : rounded[22:0];
        exp_fin  = exp_norm + (rounded[24] ? 11'sd1 : 11'sd0);

        if (a_nan || b_nan) begin
            result = QNAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            result = QNAN;
        end else if (a_inf || b_inf) begin
            result = {sign, POS_INF[30:0]};
        end else if (a_zero || b_zero) begin
            result = {sign, 31'd0};
        end else if (exp_fin >= 11'(EXP_MAX)) begin
            result = {sign, POS_INF[30:0]};
        end else if (exp_fin <= 11'sd0) begin
            result = {sign, 31'd0};
        end else begin
            result = pack_fp(sign, exp_fin[EXP_W-1:0], frac_fin);
        end
    end

endmodule

// File: rtl/fp_double_multiplier.sv
// Sequential triple-product unit z = (a*b)*c built around one shared
// combinational multiplier; four-state FSM, synchronous active-low reset.
// Build option: FP_ROUND_NEAREST_EN selects round-to-nearest-even in the core.
import fp_pkg::*;

module fp_double_multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic [31:0] input_c,
    output logic [31:0] output_z,
    output logic        z_ack
);

    state_t      state_q;
    state_t      next_state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] c_q;
    logic [31:0] t_q;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [31:0] core_z;

    // Share the multiplier: (a,b) first, then (t,c) during MUL2.
    always_comb begin
        core_a = a_q;
        core_b = b_q;
        if (state_q == MUL2) begin
            core_a = t_q;
            core_b = c_q;
        end
    end

    fp_mul_core u_mul (
        .op_a   (core_a),
        .op_b   (core_b),
        .result (core_z)
    );

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (start) next_state = MUL1;
            MUL1:    next_state = MUL2;
            MUL2:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= next_state;
    end

    // Operand capture, intermediate product, result and completion pulse.
    // NOTE: these are discrete registers, not a memory array, so clearing
    // them on reset is cheap and gives a known output after abort.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            t_q      <= '0;
            output_z <= '0;
            z_ack    <= 1'b0;
        end else begin
            z_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q <= input_a;
                        b_q <= input_b;
                        c_q <= input_c;
                    end
                end
                MUL1: t_q <= core_z;
                MUL2: begin
                    output_z <= core_z;
                    z_ack    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_double_multiplier.sv
// Directed self-checking bench for fp_double_multiplier.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fp_double_multiplier;

    logic        sys_clk_tb;
    logic        reset;
    logic        start;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [31:0] input_c;
    logic [31:0] output_z;
    logic        z_ack;

    int vectors;
    int miscompares;

`ifdef FP_ROUND_NEAREST_EN
    localparam logic [31:0] ROUND_EXP = 32'h4010_0002;
`else
    localparam logic [31:0] ROUND_EXP = 32'h4010_0001;
`endif

    fp_double_multiplier dut (
        .clk      (sys_clk_tb),
        .reset    (reset),
        .start    (start),
        .input_a  (input_a),
        .input_b  (input_b),
        .input_c  (input_c),
        .output_z (output_z),
        .z_ack    (z_ack)
    );

    initial sys_clk_tb = 1'b0;
    always #5 sys_clk_tb = ~sys_clk_tb;

    // One operation: start for one edge, scramble operands afterwards,
    // return result and the number of edges after the start edge to z_ack.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c,
                          output logic [31:0] z, output int lat);
        @(negedge sys_clk_tb);
        input_a = a;
        input_b = b;
        input_c = c;
        start   = 1'b1;
        @(negedge sys_clk_tb);
        start   = 1'b0;
        input_a = 32'hDEAD_BEEF;
        input_b = 32'h1234_5678;
        input_c = 32'hCAFE_F00D;
        lat = -1;
        z   = 32'hXXXX_XXXX;
        for (int i = 1; i <= 6; i++) begin
            @(negedge sys_clk_tb);
            if (z_ack) begin
                lat = i;
                z   = output_z;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        input_a = 32'h3F80_0000;
        input_b = 32'h3F80_0000;
        input_c = 32'h3F80_0000;
        repeat (3) @(negedge sys_clk_tb);
        vectors++;
        if (output_z !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_z: got %h expected %h", output_z, 32'h0);
        end
        vectors++;
        if (z_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ack: got %b expected 0", z_ack);
        end
        start = 1'b0;
        reset = 1'b1;
    endtask

    // start held for two edges; exactly one result pulse, no re-launch.
    task automatic test_start_two_edges();
        int acks;
        @(negedge sys_clk_tb);
        input_a = 32'hBF00_0000;
        input_b = 32'h4020_0000;
        input_c = 32'hBF80_0000;
        start   = 1'b1;
        @(negedge sys_clk_tb);          // after edge N
        @(negedge sys_clk_tb);          // after edge N+1
        start = 1'b0;
        vectors++;
        if (z_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL early_ack: got %b expected 0 at N+1", z_ack);
        end
        @(negedge sys_clk_tb);          // after edge N+2
        vectors++;
        if (z_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_n2: got %b expected 1", z_ack);
        end
        vectors++;
        if (output_z !== 32'h3FA0_0000) begin
            miscompares++;
            $display("FAIL basic_z: got %h expected %h", output_z, 32'h3FA0_0000);
        end
        @(negedge sys_clk_tb);          // after edge N+3
        vectors++;
        if (z_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_n3: got %b expected 0", z_ack);
        end
        acks = 0;
        repeat (8) begin
            @(negedge sys_clk_tb);
            if (z_ack) acks++;
        end
        vectors++;
        if (acks !== 0) begin
            miscompares++;
            $display("FAIL second_result: got %0d pulses expected 0", acks);
        end
        vectors++;
        if (output_z !== 32'h3FA0_0000) begin
            miscompares++;
            $display("FAIL hold_z: got %h expected %h", output_z, 32'h3FA0_0000);
        end
    endtask

    localparam int NV = 9;
    localparam logic [31:0] VEC_A [NV] = '{
        32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F00_0000,
        32'h3FC0_0001, 32'h3F80_0000, 32'h0080_0000, 32'h0000_0001,
        32'hFF80_0000};
    localparam logic [31:0] VEC_B [NV] = '{
        32'h4040_0000, 32'hC000_0000, 32'h0000_0000, 32'h4000_0000,
        32'h3FC0_0001, 32'h3F80_0000, 32'h3F00_0000, 32'h3F80_0000,
        32'h4000_0000};
    localparam logic [31:0] VEC_C [NV] = '{
        32'h3F00_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
        32'h3F80_0000, 32'h7F80_0001, 32'h3F80_0000, 32'hBF80_0000,
        32'hBF80_0000};
    localparam logic [31:0] VEC_Z [NV] = '{
        32'h4040_0000,  // 2*3*0.5 = 3
        32'h8000_0000,  // 0*-2 = -0
        32'h7FC0_0000,  // Inf*0 = NaN
        32'h7F80_0000,  // overflow to Inf
        ROUND_EXP,      // rounding mode dependent
        32'h7FC0_0000,  // NaN operand
        32'h0000_0000,  // exponent underflow flushes
        32'h8000_0000,  // denormal as zero, sign kept
        32'h7F80_0000}; // -Inf*2*-1 = +Inf
    localparam string VEC_N [NV] = '{
        "mul_3", "neg_zero", "inf_x_zero", "overflow", "rounding",
        "nan_in", "underflow", "denormal", "inf_sign"};

    task automatic test_vectors();
        logic [31:0] z;
        int lat;
        for (int i = 0; i < NV; i++) begin
            run_op(VEC_A[i], VEC_B[i], VEC_C[i], z, lat);
            vectors++;
            if (lat !== 2) begin
                miscompares++;
                $display("FAIL %s_latency: got %0d expected 2", VEC_N[i], lat);
            end
            vectors++;
            if (z !== VEC_Z[i]) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", VEC_N[i], z, VEC_Z[i]);
            end
        end
    endtask

    // Reset at edge N+1 aborts; a fresh start afterwards still works.
    task automatic test_reset_abort();
        logic [31:0] z;
        int lat;
        int acks;
        @(negedge sys_clk_tb);
        input_a = 32'h4000_0000;
        input_b = 32'h4000_0000;
        input_c = 32'h4000_0000;
        start   = 1'b1;
        @(negedge sys_clk_tb);          // after edge N
        start = 1'b0;
        reset = 1'b0;
        @(negedge sys_clk_tb);          // after edge N+1 (reset)
        reset = 1'b1;
        vectors++;
        if (output_z !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_z: got %h expected %h", output_z, 32'h0);
        end
        acks = (z_ack === 1'b1) ? 1 : 0;
        repeat (5) begin
            @(negedge sys_clk_tb);
            if (z_ack) acks++;
        end
        vectors++;
        if (acks !== 0) begin
            miscompares++;
            $display("FAIL abort_ack: got %0d pulses expected 0", acks);
        end
        run_op(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, z, lat);
        vectors++;
        if (lat !== 2 || z !== 32'h4100_0000) begin
            miscompares++;
            $display("FAIL after_abort: got %h lat %0d expected %h lat 2",
                     z, lat, 32'h4100_0000);
        end
    endtask

    // start held high: one result every 4 cycles, operands latched only in IDLE.
    task automatic test_back_to_back();
        int          ack_cyc [3];
        logic [31:0] ack_val [3];
        int          n_ack;
        int          exp_cyc [3] = '{2, 6, 10};
        logic [31:0] exp_val [3] = '{32'h4040_0000, 32'h4100_0000, 32'h4100_0000};
        n_ack = 0;
        for (int k = 0; k < 3; k++) begin
            ack_cyc[k] = -1;
            ack_val[k] = '0;
        end
        @(negedge sys_clk_tb);
        input_a = 32'h4000_0000;
        input_b = 32'h4040_0000;
        input_c = 32'h3F00_0000;
        start   = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge sys_clk_tb);
            if (cyc == 0) begin
                input_a = 32'h4000_0000;
                input_b = 32'h4000_0000;
                input_c = 32'h4000_0000;
            end
            if (z_ack) begin
                if (n_ack < 3) begin
                    ack_cyc[n_ack] = cyc;
                    ack_val[n_ack] = output_z;
                end
                n_ack++;
            end
        end
        start = 1'b0;
        vectors++;
        if (n_ack !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results expected 3", n_ack);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (ack_cyc[k] !== exp_cyc[k] || ack_val[k] !== exp_val[k]) begin
                miscompares++;
                $display("FAIL b2b_%0d: got %h at cycle %0d expected %h at cycle %0d",
                         k, ack_val[k], ack_cyc[k], exp_val[k], exp_cyc[k]);
            end
        end
        repeat (4) @(negedge sys_clk_tb);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_start_two_edges();
        test_vectors();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
